// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit R/W registers with per-register
// write pulses. Write and read channels run independent two-state FSMs.
module axi_lite_reg_slave #(
    parameter int ADDR_W   = 64,
    parameter int NUM_REGS = 16
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [ADDR_W-1:0]        s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [NUM_REGS-1:0][31:0] regs;

    logic              aw_held, w_held;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_W-1:0] commit_addr;
    logic [31:0]       commit_data;
    logic [3:0]        commit_strb;
    logic              w_in_range, r_in_range;
    logic [IDX_W-1:0]  widx, ridx;
    logic              unused_bits;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;

    // A held beat takes priority over the live bus for the commit operands
    assign commit_addr = aw_held ? aw_addr_q : s_axi_awaddr;
    assign commit_data = w_held ? w_data_q : s_axi_wdata;
    assign commit_strb = w_held ? w_strb_q : s_axi_wstrb;
    assign commit      = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

    assign w_in_range = commit_addr[ADDR_W-1:2] < (ADDR_W-2)'(NUM_REGS);
    assign r_in_range = s_axi_araddr[ADDR_W-1:2] < (ADDR_W-2)'(NUM_REGS);
    assign widx       = commit_addr[2 +: IDX_W];
    assign ridx       = s_axi_araddr[2 +: IDX_W];
    assign unused_bits = ^{commit_addr[1:0], s_axi_araddr[1:0]};

    assign reg_q = regs;

    // Write FSM state register
    always_ff @(posedge aclk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_next;
    end

    // Write FSM next state: commit moves to response, B handshake returns
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: if (commit) w_next = W_RESP;
            W_RESP: if (s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs: readies only for channels not yet latched
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = ~aw_held & ~reset;
                s_axi_wready  = ~w_held & ~reset;
            end
            W_RESP: s_axi_bvalid = 1'b1;
            default: ;
        endcase
    end

    // AW/W holding latches; cleared on commit
    always_ff @(posedge aclk) begin
        if (reset || commit) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
        end
    end

    // Register bank byte-lane update, write pulse and write response code
    always_ff @(posedge aclk) begin
        if (reset) begin
            regs         <= '0;
            reg_wr_pulse <= '0;
            s_axi_bresp  <= 2'b00;
        end else begin
            reg_wr_pulse <= '0;
            if (commit) begin
                if (w_in_range) begin
                    for (int b = 0; b < 4; b++)
                        if (commit_strb[b]) regs[widx][8*b +: 8] <= commit_data[8*b +: 8];
                    reg_wr_pulse <= NUM_REGS'(1) << widx;
                    s_axi_bresp  <= 2'b00;
                end else begin
                    s_axi_bresp  <= 2'b10;
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge aclk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_next;
    end

    // Read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: if (ar_hs) r_next = R_DATA;
            R_DATA: if (s_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: s_axi_arready = ~reset;
            R_DATA: s_axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Read data capture: pre-edge register value, so a same-edge write is not seen
    always_ff @(posedge aclk) begin
        if (reset) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b00;
        end else if (ar_hs) begin
            s_axi_rdata <= r_in_range ? regs[ridx] : 32'h0;
            s_axi_rresp <= r_in_range ? 2'b00 : 2'b10;
        end
    end
endmodule
